ce_scheduler: RTL and testbench

//  Sequences system start-up behind the PLL and schedules every clock enable on clk_sys.

---
 rtl/ce_scheduler.sv | 125 ++++++++++++
 tb/tb_ce_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_scheduler.sv
// Start-up sequencer and clock-enable scheduler on clk_sys: PLL-lock gated reset release, 16/8/4/1 MHz
// enables, fractional 7.16 MHz enable, CPU enable. Define CE_TURBO_EN to build the speed-select logic.
module ce_scheduler #(
  parameter int unsigned DIV16     = 6,
  parameter int unsigned LOCK_HOLD = 1024,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned PSG_INC   = 1251142
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic [1:0] speed_req,
  output logic       sys_rst_n,
  output logic       ce_16m,
  output logic       ce_8m,
  output logic       ce_4m,
  output logic       ce_1m,
  output logic       ce_7_16m,
  output logic       ce_cpu,
  output logic [1:0] speed_cur
);

  localparam int unsigned DW = (DIV16 > 1) ? $clog2(DIV16) : 1;
  localparam int unsigned HW = $clog2(LOCK_HOLD + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV16 - 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(LOCK_HOLD);
  localparam logic [ACC_W:0] INC      = (ACC_W + 1)'(PSG_INC);

  logic          lk_meta;
  logic          lk_s;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;

  logic [DW-1:0]    div_cnt;
  logic [3:0]       ph;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             tick;

  always_comb begin
    hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
  end

  // Release is decided from the next count value so sys_rst_n rises on the
  // same edge that hold_cnt reaches LOCK_HOLD.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta   <= 1'b0;
      lk_s      <= 1'b0;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
      if (!lk_s) begin
        hold_cnt  <= '0;
        sys_rst_n <= 1'b0;
      end else begin
        hold_cnt  <= hold_nxt;
        sys_rst_n <= (hold_nxt == HOLD_MAX);
      end
    end
  end

  always_comb begin
    tick    = (div_cnt == DIV_LAST);
    acc_sum = {1'b0, acc} + INC;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      ph       <= '0;
      acc      <= '0;
      ce_16m   <= 1'b0;
      ce_8m    <= 1'b0;
      ce_4m    <= 1'b0;
      ce_1m    <= 1'b0;
      ce_7_16m <= 1'b0;
    end else if (!sys_rst_n) begin
      div_cnt  <= '0;
      ph       <= '0;
      acc      <= '0;
      ce_16m   <= 1'b0;
      ce_8m    <= 1'b0;
      ce_4m    <= 1'b0;
      ce_1m    <= 1'b0;
      ce_7_16m <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + DW'(1);
      if (tick) ph <= ph + 4'd1;
      ce_16m   <= tick;
      ce_8m    <= tick & ~ph[0];
      ce_4m    <= tick & (ph[1:0] == 2'd0);
      ce_1m    <= tick & (ph == 4'd0);
      acc      <= acc_sum[ACC_W-1:0];
      ce_7_16m <= acc_sum[ACC_W];
    end
  end

`ifdef CE_TURBO_EN
  // Sampling only while ce_1m is high keeps a speed change on a 1 MHz slot boundary.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      speed_cur <= 2'd0;
    end else if (ce_1m) begin
      speed_cur <= (speed_req == 2'd3) ? 2'd0 : speed_req;
    end
  end

  always_comb begin
    case (speed_cur)
      2'd1:    ce_cpu = ce_8m;
      2'd2:    ce_cpu = ce_16m;
      default: ce_cpu = ce_4m;
    endcase
  end
`else
  logic unused_speed_req;
  assign unused_speed_req = ^speed_req;
  assign speed_cur        = 2'd0;
  assign ce_cpu           = ce_4m;
`endif

endmodule

// File: tb/tb_ce_scheduler.sv
// Self-checking bench for ce_scheduler: table-driven pulse-count windows, randomized run against an
// arithmetic reference model, and hand-written lock-drop, async-reset and speed-change sequences.
module tb_ce_scheduler;

  localparam int unsigned DIV  = 6;
  localparam int unsigned HOLD = 16;
  localparam int unsigned AW   = 24;
  localparam int unsigned INCV = 1251142;

  logic       clk_sys;
  logic       rst_n;
  logic       pll_locked;
  logic [1:0] speed_req;
  logic       sys_rst_n;
  logic       ce_16m, ce_8m, ce_4m, ce_1m, ce_7_16m, ce_cpu;
  logic [1:0] speed_cur;

  int unsigned n_cmp;
  int unsigned n_err;

  ce_scheduler #(
    .DIV16     (DIV),
    .LOCK_HOLD (HOLD),
    .ACC_W     (AW),
    .PSG_INC   (INCV)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .speed_req  (speed_req),
    .sys_rst_n  (sys_rst_n),
    .ce_16m     (ce_16m),
    .ce_8m      (ce_8m),
    .ce_4m      (ce_4m),
    .ce_1m      (ce_1m),
    .ce_7_16m   (ce_7_16m),
    .ce_cpu     (ce_cpu),
    .speed_cur  (speed_cur)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int unsigned window;
    int unsigned e16;
    int unsigned e8;
    int unsigned e4;
    int unsigned e1;
  } win_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [5:0] all_out();
    return {sys_rst_n, ce_16m, ce_8m, ce_4m, ce_1m, ce_7_16m};
  endfunction

  function automatic longint unsigned carries(input longint unsigned n);
    return (n * longint'(INCV)) >> AW;
  endfunction

  function automatic logic [1:0] map_speed(input logic [1:0] r);
`ifdef CE_TURBO_EN
    return (r == 2'd3) ? 2'd0 : r;
`else
    return 2'd0 & r;
`endif
  endfunction

  // Raise pll_locked and count edges until sys_rst_n goes high (0 on timeout).
  task automatic lock_and_measure(output int unsigned edges);
    edges = 0;
    pll_locked = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (sys_rst_n) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic do_release();
    int unsigned e;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    #2;
    step();
    rst_n = 1'b1;
    step();
    step();
    lock_and_measure(e);
    check("release_edges", e, HOLD + 2);
  endtask

  task automatic wait_ce1m(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ce_1m) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check(name, seen, 1);
  endtask

  win_t tbl[5];

  initial begin
    int unsigned e;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    speed_req = 2'd0;

    // Reset state
    #3;
    check("reset_outputs", all_out(), 0);
    check("reset_ce_cpu", ce_cpu, 0);
    check("reset_speed_cur", speed_cur, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("unlocked_sys_rst_n", sys_rst_n, 0);

    // Lock sequencing edge by edge
    pll_locked = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      check($sformatf("lock_edge%0d_sys_rst_n", k), sys_rst_n, (k >= HOLD + 2) ? 1 : 0);
      check($sformatf("lock_edge%0d_ce", k), {ce_16m, ce_8m, ce_4m, ce_1m, ce_7_16m, ce_cpu}, 0);
    end

    // Pulse-count windows after release
    tbl[0] = '{6, 1, 1, 1, 1};
    tbl[1] = '{12, 2, 1, 1, 1};
    tbl[2] = '{24, 4, 2, 1, 1};
    tbl[3] = '{96, 16, 8, 4, 1};
    tbl[4] = '{960, 160, 80, 40, 10};
    for (int t = 0; t < 5; t++) begin
      int unsigned c16, c8, c4, c1, c7, ccpu, bad_coin, first;
      c16 = 0; c8 = 0; c4 = 0; c1 = 0; c7 = 0; ccpu = 0; bad_coin = 0; first = 0;
      speed_req = 2'd0;
      do_release();
      for (int n = 1; n <= int'(tbl[t].window); n++) begin
        step();
        c16 += ce_16m; c8 += ce_8m; c4 += ce_4m; c1 += ce_1m; c7 += ce_7_16m; ccpu += ce_cpu;
        if (ce_1m && !(ce_4m && ce_8m && ce_16m)) bad_coin++;
        if (ce_16m && first == 0) first = n;
      end
      check($sformatf("win%0d_ce16", t), c16, tbl[t].e16);
      check($sformatf("win%0d_ce8", t), c8, tbl[t].e8);
      check($sformatf("win%0d_ce4", t), c4, tbl[t].e4);
      check($sformatf("win%0d_ce1", t), c1, tbl[t].e1);
      check($sformatf("win%0d_ce7", t), c7, carries(tbl[t].window));
      check($sformatf("win%0d_cecpu", t), ccpu, tbl[t].e4);
      check($sformatf("win%0d_coincide", t), bad_coin, 0);
      check($sformatf("win%0d_first", t), first, DIV);
    end

    // Randomized run against arithmetic reference model
    begin
      int unsigned b16, b8, b4, b1, b7, bcpu, bspd, c7, gmin, gmax, last7;
      logic [1:0] cur_m, req_prev;
      logic x16, x8, x4, x1, x7, xcpu;
      b16 = 0; b8 = 0; b4 = 0; b1 = 0; b7 = 0; bcpu = 0; bspd = 0; c7 = 0;
      gmin = 1000; gmax = 0; last7 = 0;
      speed_req = 2'd0;
      do_release();
      cur_m = 2'd0;
      req_prev = speed_req;
      for (int n = 1; n <= 19200; n++) begin
        step();
        if (n >= 2 && ((n - 1) % (16 * DIV)) == DIV) cur_m = map_speed(req_prev);
        x16 = (n % DIV) == 0;
        x8  = (n % (2 * DIV)) == DIV;
        x4  = (n % (4 * DIV)) == DIV;
        x1  = (n % (16 * DIV)) == DIV;
        x7  = carries(n) != carries(n - 1);
        xcpu = (cur_m == 2'd2) ? x16 : (cur_m == 2'd1) ? x8 : x4;
        b16 += (ce_16m !== x16); b8 += (ce_8m !== x8); b4 += (ce_4m !== x4);
        b1 += (ce_1m !== x1); b7 += (ce_7_16m !== x7); bcpu += (ce_cpu !== xcpu);
        bspd += (speed_cur !== cur_m);
        if (ce_7_16m) begin
          c7++;
          if (last7 != 0) begin
            if (n - last7 < gmin) gmin = n - last7;
            if (n - last7 > gmax) gmax = n - last7;
          end
          last7 = n;
        end
        req_prev = speed_req;
        if ($urandom_range(19) == 0) speed_req = 2'($urandom_range(3));
        req_prev = speed_req;
      end
      check("rand_ce16_bad", b16, 0);
      check("rand_ce8_bad", b8, 0);
      check("rand_ce4_bad", b4, 0);
      check("rand_ce1_bad", b1, 0);
      check("rand_ce7_bad", b7, 0);
      check("rand_cecpu_bad", bcpu, 0);
      check("rand_speed_bad", bspd, 0);
      check("rand_ce7_count", c7, carries(19200));
      check("rand_ce7_gap_min", gmin, 13);
      check("rand_ce7_gap_max", gmax, 14);
    end

    // Speed request changed mid-slot
    begin
      int unsigned bad, ccpu;
      speed_req = 2'd0;
      do_release();
      wait_ce1m("spd_wait1");
      for (int i = 0; i < 30; i++) step();
      speed_req = 2'd2;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
        if (ce_1m) break;
        bad += (ce_cpu !== ce_4m) || (speed_cur !== 2'd0);
        step();
      end
      check("spd_midslot_hold", bad, 0);
      check("spd_at_ce1m", speed_cur, 0);
      step();
      check("spd_applied", speed_cur, map_speed(2'd2));
      ccpu = 0;
      for (int i = 0; i < 96; i++) begin
        step();
        ccpu += ce_cpu;
      end
`ifdef CE_TURBO_EN
      check("spd_cecpu_rate", ccpu, 16);
`else
      check("spd_cecpu_rate", ccpu, 4);
`endif
      speed_req = 2'd3;
      wait_ce1m("spd_wait3");
      step();
      check("spd_reserved", speed_cur, 0);
      speed_req = 2'd1;
      for (int i = 0; i < 10; i++) step();
      speed_req = 2'd0;
      wait_ce1m("spd_wait4");
      step();
      check("spd_glitch_ignored", speed_cur, 0);
    end

    // PLL lock lost for 3 cycles
    begin
      int unsigned drop_at, live;
      speed_req = 2'd0;
      do_release();
      for (int i = 0; i < 50; i++) step();
      pll_locked = 1'b0;
      drop_at = 0;
      for (int i = 1; i <= 3; i++) begin
        step();
        if (!sys_rst_n && drop_at == 0) drop_at = i;
      end
      check("drop_sys_rst_n_edge", drop_at, 3);
      step();
      live = 0;
      for (int i = 0; i < 12; i++) begin
        live += ce_16m | ce_8m | ce_4m | ce_1m | ce_7_16m | ce_cpu;
        if (i < 11) step();
      end
      check("drop_enables_stop", live, 0);
      lock_and_measure(e);
      check("relock_edges", e, HOLD + 2);
    end

    // Async reset mid-slot at top speed
    begin
      speed_req = 2'd2;
      wait_ce1m("rst_wait");
      step();
      for (int i = 0; i < 20; i++) step();
      check("rst_pre_speed", speed_cur, map_speed(2'd2));
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", all_out(), 0);
      check("rst_async_cecpu", ce_cpu, 0);
      check("rst_async_speed", speed_cur, 0);
      pll_locked = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("rst_after_speed", speed_cur, 0);
      check("rst_after_sys_rst_n", sys_rst_n, 0);
      lock_and_measure(e);
      check("rst_relock_edges", e, HOLD + 2);
      check("rst_relock_speed", speed_cur, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
